// File: rtl/wb_slave_mem.sv
// ============================================================================
// wb_slave_mem : Wishbone B4 classic slave, 64-bit data + 16-bit tag memory.
// Optional RTY injection enabled by defining WB_SLAVE_RTY_INJECT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_slave_mem #(
    parameter int ADDR_W       = 8,
    parameter int WAIT_STATES  = 1,
    parameter int RTY_INTERVAL = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [63:0] ADR_I,
    input  logic [7:0]  SEL_I,
    input  logic [63:0] DAT_I,
    input  logic [15:0] TGD_I,
    output logic [63:0] DAT_O,
    output logic [15:0] TGD_O,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic        RTY_O
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int DEPTH = 2 ** ADDR_W;

    state_t      state_q;
    logic [3:0]  wcnt_q;
    logic        rdy_q;
    logic        ack_q, err_q, rty_q;
    logic [63:0] dat_q;
    logic [15:0] tgd_q;
    logic [63:0] mem_q [DEPTH];
    logic [15:0] tag_q [DEPTH];

    logic              req;
    logic              oor;
    logic [ADDR_W-1:0] idx;
    logic [63:0]       lane_mask;
    logic              enter_d, rty_d, err_d, ack_d, wr_d;
    logic              w_unused_bits;

    assign req = CYC_I & STB_I;
    assign idx = ADR_I[ADDR_W+2:3];
    assign oor = |ADR_I[63:ADDR_W+3];
    assign w_unused_bits = ^{ADR_I[2:0], 8'(RTY_INTERVAL)};

    for (genvar n = 0; n < 8; n++) begin : g_lane
        assign lane_mask[8*n +: 8] = {8{SEL_I[n]}};
    end

    always_comb begin
        enter_d = 1'b0;
        case (state_q)
            S_IDLE:  enter_d = rdy_q & req & (WAIT_STATES == 0);
            S_WAIT:  enter_d = req & (wcnt_q == 4'd1);
            default: enter_d = 1'b0;
        endcase
    end

`ifdef WB_SLAVE_RTY_INJECT_EN
    logic [7:0] rcnt_q;
    assign rty_d = (rcnt_q == 8'(RTY_INTERVAL - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt_q <= '0;
        end else if (enter_d) begin
            rcnt_q <= rty_d ? 8'd0 : rcnt_q + 8'd1;
        end
    end
`else
    assign rty_d = 1'b0;
`endif

    assign err_d = !rty_d && oor;
    assign ack_d = !rty_d && !oor;
    assign wr_d  = enter_d && ack_d && WE_I;

    // rdy_q blocks acceptance on the edge that releases reset, so a request
    // racing the release can never produce a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            rdy_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            dat_q   <= '0;
            tgd_q   <= '0;
        end else begin
            rdy_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (rdy_q && req) begin
                        if (WAIT_STATES == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            wcnt_q  <= 4'(WAIT_STATES);
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                        if (wcnt_q == 4'd1) begin
                            state_q <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rty_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            if (enter_d) begin
                ack_q <= ack_d;
                err_q <= err_d;
                rty_q <= rty_d;
                if (ack_d && !WE_I) begin
                    dat_q <= mem_q[idx];
                    tgd_q <= tag_q[idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_d) begin
            mem_q[idx] <= (mem_q[idx] & ~lane_mask) | (DAT_I & lane_mask);
            if (|SEL_I) begin
                tag_q[idx] <= TGD_I;
            end
        end
    end

    assign DAT_O = dat_q;
    assign TGD_O = tgd_q;
    assign ACK_O = ack_q;
    assign ERR_O = err_q;
    assign RTY_O = rty_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_slave_mem.sv
// ============================================================================
// tb_wb_slave_mem : scoreboard bench for wb_slave_mem with a word-array model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_slave_mem;

    localparam int ADDR_W = 8;
    localparam int WS     = 1;
    localparam int RTY_N  = 4;
`ifdef WB_SLAVE_RTY_INJECT_EN
    localparam bit RTY_ON = 1'b1;
`else
    localparam bit RTY_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [63:0] adr = '0, dat = '0;
    logic [7:0]  sel = '0;
    logic [15:0] tgd = '0;
    logic [63:0] dat_o;
    logic [15:0] tgd_o;
    logic        ack_o, err_o, rty_o;

    always #5 clk = ~clk;

    wb_slave_mem #(.ADDR_W(ADDR_W), .WAIT_STATES(WS), .RTY_INTERVAL(RTY_N)) dut (
        .clk(clk), .rst(rst),
        .CYC_I(cyc), .STB_I(stb), .WE_I(we), .ADR_I(adr), .SEL_I(sel),
        .DAT_I(dat), .TGD_I(tgd),
        .DAT_O(dat_o), .TGD_O(tgd_o),
        .ACK_O(ack_o), .ERR_O(err_o), .RTY_O(rty_o)
    );

    // kind: 0 = ACK, 1 = ERR, 2 = RTY
    typedef struct {
        int          kind;
        bit          chk;
        logic [63:0] dat;
        logic [15:0] tgd;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] m_dat [256];
    logic [15:0] m_tag [256];
    bit          m_valid [256];
    logic [63:0] last_dat = '0;
    logic [15:0] last_tgd = '0;
    int          resp_n = 0;
    bit          prev_term = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        int   k;
        exp_t e;
        if (rst && (ack_o || err_o || rty_o)) begin
            k = ack_o ? 0 : (err_o ? 1 : 2);
            checks++;
            if ($countones({ack_o, err_o, rty_o}) != 1 || prev_term) begin
                failures++;
                $display("FAIL term_excl ack=%0b err=%0b rty=%0b prev=%0b required one-hot single cycle",
                         ack_o, err_o, rty_o, prev_term);
            end
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_term kind=%0d required none", k);
            end else begin
                e = sbq.pop_front();
                if (k != e.kind) begin
                    failures++;
                    $display("FAIL resp_kind got=%0d required=%0d", k, e.kind);
                end else if (e.chk && (dat_o !== e.dat || tgd_o !== e.tgd)) begin
                    failures++;
                    $display("FAIL resp_data got=%h/%h required=%h/%h", dat_o, tgd_o, e.dat, e.tgd);
                end
            end
        end
        prev_term = rst && (ack_o || err_o || rty_o);
    end

    // Reference model: decides the termination and applies the memory effect.
    function automatic exp_t predict(input bit w, input logic [63:0] a, input logic [7:0] s,
                                     input logic [63:0] d, input logic [15:0] t);
        exp_t        e;
        int          i;
        logic [63:0] word;
        i = int'(a[ADDR_W+2:3]);
        e.kind = 0; e.chk = 1'b0; e.dat = last_dat; e.tgd = last_tgd;
        if (RTY_ON && (resp_n % RTY_N) == RTY_N - 1) begin
            e.kind = 2; e.chk = 1'b1;
        end else if ((a >> (ADDR_W + 3)) != 64'd0) begin
            e.kind = 1; e.chk = 1'b1;
        end else if (w) begin
            word = m_dat[i];
            for (int n = 0; n < 8; n++) if (s[n]) word[8*n +: 8] = d[8*n +: 8];
            m_dat[i] = word;
            if (s != 8'h00) m_tag[i] = t;
            if (s == 8'hFF) m_valid[i] = 1'b1;
        end else begin
            e.chk = 1'b1; e.dat = m_dat[i]; e.tgd = m_tag[i];
            last_dat = e.dat; last_tgd = e.tgd;
        end
        resp_n++;
        return e;
    endfunction

    task automatic xfer(input bit w, input logic [63:0] a, input logic [7:0] s,
                        input logic [63:0] d, input logic [15:0] t);
        int lat;
        bit got;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d; tgd = t;
        sbq.push_back(predict(w, a, s, d, t));
        lat = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); lat++; #1;
            got = ack_o || err_o || rty_o;
        end
        checks++;
        if (!got || lat != WS + 1) begin
            failures++;
            $display("FAIL latency got=%0d required=%0d", got ? lat : -1, WS + 1);
            if (!got) sbq.delete();
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
    endtask

    task automatic abort_write(input logic [63:0] a, input logic [63:0] d);
        bit seen;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = 8'hFF; dat = d; tgd = 16'hDEAD;
        @(posedge clk); #1;
        cyc = 1'b0;
        seen = 1'b0;
        repeat (WS + 3) begin
            @(posedge clk); #1;
            seen |= ack_o || err_o || rty_o;
        end
        stb = 1'b0;
        chk("abort_no_term", 64'(seen), 64'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          i;
        logic [63:0] a;
        #12;
        chk("rst_ack", 64'(ack_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_rty", 64'(rty_o), 64'd0);
        chk("rst_dat", dat_o, 64'd0);
        chk("rst_tgd", 64'(tgd_o), 64'd0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);

        xfer(1'b1, 64'h40, 8'hFF, 64'h0123456789ABCDEF, 16'h5A5A);
        xfer(1'b0, 64'h40, 8'h00, 64'd0, 16'd0);
        xfer(1'b1, 64'h48, 8'hFF, {64{1'b1}}, 16'h1111);
        xfer(1'b1, 64'h48, 8'h0F, 64'd0, 16'h2222);
        xfer(1'b0, 64'h48, 8'hFF, 64'd0, 16'd0);
        xfer(1'b0, 64'h800, 8'hFF, 64'd0, 16'd0);
        abort_write(64'h40, 64'hCAFEF00DCAFEF00D);
        xfer(1'b0, 64'h40, 8'hFF, 64'd0, 16'd0);
        repeat (5) xfer(1'b0, 64'h40, 8'hFF, 64'd0, 16'd0);

        // Reset while a write sits in WAIT: outputs clear at once, no write.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 64'h48; sel = 8'hFF;
        dat = 64'hBADBADBADBADBAD0; tgd = 16'hBBBB;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("rstw_ack", 64'(ack_o), 64'd0);
        chk("rstw_err", 64'(err_o), 64'd0);
        chk("rstw_rty", 64'(rty_o), 64'd0);
        chk("rstw_dat", dat_o, 64'd0);
        chk("rstw_tgd", 64'(tgd_o), 64'd0);
        last_dat = '0; last_tgd = '0; resp_n = 0;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        xfer(1'b0, 64'h48, 8'hFF, 64'd0, 16'd0);

        for (int n = 0; n < 300; n++) begin
            i = $urandom_range(15);
            a = {53'd0, 8'(i), 3'($urandom_range(7))};
            case ($urandom_range(9))
                0: begin
                    a = {$urandom, $urandom} | (64'd1 << $urandom_range(63, ADDR_W + 3));
                    xfer(1'($urandom_range(1)), a, 8'($urandom), {$urandom, $urandom}, 16'($urandom));
                end
                1: abort_write(a, {$urandom, $urandom});
                2, 3, 4, 5: begin
                    if (m_valid[i]) xfer(1'b0, a, 8'($urandom), 64'd0, 16'd0);
                    else xfer(1'b1, a, 8'hFF, {$urandom, $urandom}, 16'($urandom));
                end
                default: begin
                    if (m_valid[i]) xfer(1'b1, a, 8'($urandom), {$urandom, $urandom}, 16'($urandom));
                    else xfer(1'b1, a, 8'hFF, {$urandom, $urandom}, 16'($urandom));
                end
            endcase
        end

        repeat (3) @(posedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
